// File: rtl/gp_input_stage_if.sv
// Parameter/vertex bus between the memory manager, gp_input_stage and the geometry stage.
// master = memory-manager/downstream side, slave = gp_input_stage.
interface gp_input_stage_if #(parameter int DATA_W = 16);
  logic              iEnable, iInitObj, iInitVtx, iVtxReady;
  logic [DATA_W-1:0] iCamVerX, iCamVerY, iCamVerZ, iCamDc;
  logic [DATA_W-1:0] iCosRoll, iCosPitch, iCosYaw, iSenRoll, iSenPitch, iSenYaw;
  logic [DATA_W-1:0] iScaleX, iScaleY, iScaleZ, iTranslX, iTranslY, iTranslZ;
  logic [DATA_W-1:0] iVertexX, iVertexY, iVertexZ;
  logic              oBusy, oOverflow, oVtxValid, oFrameDone;
  logic [DATA_W-1:0] oVertexX, oVertexY, oVertexZ;
  logic [DATA_W-1:0] oCamVerX, oCamVerY, oCamVerZ, oCamDc;
  logic [DATA_W-1:0] oCosRoll, oCosPitch, oCosYaw, oSenRoll, oSenPitch, oSenYaw;
  logic [DATA_W-1:0] oScaleX, oScaleY, oScaleZ, oTranslX, oTranslY, oTranslZ;
  logic [7:0]        oObjCount;
  logic [15:0]       oVtxCount;

  modport master (
    output iEnable, iInitObj, iInitVtx, iVtxReady,
           iCamVerX, iCamVerY, iCamVerZ, iCamDc,
           iCosRoll, iCosPitch, iCosYaw, iSenRoll, iSenPitch, iSenYaw,
           iScaleX, iScaleY, iScaleZ, iTranslX, iTranslY, iTranslZ,
           iVertexX, iVertexY, iVertexZ,
    input  oBusy, oOverflow, oVtxValid, oFrameDone, oVertexX, oVertexY, oVertexZ,
           oCamVerX, oCamVerY, oCamVerZ, oCamDc,
           oCosRoll, oCosPitch, oCosYaw, oSenRoll, oSenPitch, oSenYaw,
           oScaleX, oScaleY, oScaleZ, oTranslX, oTranslY, oTranslZ,
           oObjCount, oVtxCount
  );

  modport slave (
    input  iEnable, iInitObj, iInitVtx, iVtxReady,
           iCamVerX, iCamVerY, iCamVerZ, iCamDc,
           iCosRoll, iCosPitch, iCosYaw, iSenRoll, iSenPitch, iSenYaw,
           iScaleX, iScaleY, iScaleZ, iTranslX, iTranslY, iTranslZ,
           iVertexX, iVertexY, iVertexZ,
    output oBusy, oOverflow, oVtxValid, oFrameDone, oVertexX, oVertexY, oVertexZ,
           oCamVerX, oCamVerY, oCamVerZ, oCamDc,
           oCosRoll, oCosPitch, oCosYaw, oSenRoll, oSenPitch, oSenYaw,
           oScaleX, oScaleY, oScaleZ, oTranslX, oTranslY, oTranslZ,
           oObjCount, oVtxCount
  );
endinterface

// File: rtl/gp_input_stage.sv
// Graphics-pipeline input stage: camera/object parameter capture plus vertex FIFO.
// Optional accepted-vertex counter on oVtxCount is built when GP_INPUT_VTXCNT_EN is defined.
module gp_input_stage #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 16
) (
  input logic          iClock,
  input logic          iReset,
  gp_input_stage_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = 12 * DATA_W;
  localparam logic [1:0] IDLE = 2'd0, WAIT_OBJ = 2'd1, STREAM = 2'd2, DRAIN = 2'd3;

  logic [1:0]          state, stateNext;
  logic [3*DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]         wrPtr, rdPtr, wrPtrNext, rdPtrNext;
  logic [OW-1:0]       objIn, objAct, objShadow;
  logic [4*DATA_W-1:0] camAct;
  logic                pending, pendingNext, busyR, busyNext, ovfR, frameDone;
  logic [7:0]          objCnt;
  logic                empty, full, emptyNext, fullNext, inFrame, objAcc, vtxAcc;
  logic                dropPulse, pop, toShadow, objDirect, applyShadow;
  logic                frameStart, frameEnd;

  assign objIn = {bus.iCosRoll, bus.iCosPitch, bus.iCosYaw, bus.iSenRoll, bus.iSenPitch,
                  bus.iSenYaw, bus.iScaleX, bus.iScaleY, bus.iScaleZ, bus.iTranslX,
                  bus.iTranslY, bus.iTranslZ};

  assign empty     = (wrPtr == rdPtr);
  assign full      = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign inFrame   = (state == WAIT_OBJ || state == STREAM) && bus.iEnable;
  assign objAcc    = inFrame && bus.iInitObj && !busyR;
  // A same-cycle vertex rides with the new object only when nothing older is queued.
  assign vtxAcc    = inFrame && bus.iInitVtx && !busyR && !full &&
                     (state == STREAM || objAcc) && !(objAcc && !empty);
  assign dropPulse = inFrame && ((bus.iInitObj && !objAcc) || (bus.iInitVtx && !vtxAcc));
  assign pop       = !empty && bus.iVtxReady;
  assign toShadow  = objAcc && !empty;
  assign objDirect = objAcc && empty;

  assign wrPtrNext   = wrPtr + {{AW{1'b0}}, vtxAcc};
  assign rdPtrNext   = rdPtr + {{AW{1'b0}}, pop};
  assign emptyNext   = (wrPtrNext == rdPtrNext);
  assign fullNext    = (wrPtrNext[AW] != rdPtrNext[AW]) &&
                       (wrPtrNext[AW-1:0] == rdPtrNext[AW-1:0]);
  assign applyShadow = pending && emptyNext;
  assign pendingNext = toShadow || (pending && !emptyNext);
  assign frameStart  = (state == IDLE) && bus.iEnable;
  assign frameEnd    = (state == DRAIN) && empty && !pending;

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (bus.iEnable) stateNext = WAIT_OBJ;
      WAIT_OBJ: if (!bus.iEnable) stateNext = DRAIN;
                else if (objAcc) stateNext = STREAM;
      STREAM:   if (!bus.iEnable) stateNext = DRAIN;
      default:  if (frameEnd) stateNext = IDLE;
    endcase
  end

  assign busyNext = fullNext || pendingNext || !(stateNext == WAIT_OBJ || stateNext == STREAM);

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state     <= IDLE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      pending   <= 1'b0;
      busyR     <= 1'b0;
      ovfR      <= 1'b0;
      frameDone <= 1'b0;
      objCnt    <= '0;
      camAct    <= '0;
      objAct    <= '0;
      objShadow <= '0;
    end else begin
      state     <= stateNext;
      wrPtr     <= wrPtrNext;
      rdPtr     <= rdPtrNext;
      pending   <= pendingNext;
      busyR     <= busyNext;
      frameDone <= frameEnd;
      if (frameStart) begin
        camAct <= {bus.iCamVerX, bus.iCamVerY, bus.iCamVerZ, bus.iCamDc};
        objCnt <= '0;
        ovfR   <= 1'b0;
      end else begin
        if (dropPulse) ovfR <= 1'b1;
        if (objAcc && objCnt != 8'hFF) objCnt <= objCnt + 8'd1;
      end
      if (toShadow) objShadow <= objIn;
      if (objDirect) objAct <= objIn;
      else if (applyShadow) objAct <= objShadow;
    end
  end

  always_ff @(posedge iClock) begin
    if (vtxAcc) mem[wrPtr[AW-1:0]] <= {bus.iVertexX, bus.iVertexY, bus.iVertexZ};
  end

`ifdef GP_INPUT_VTXCNT_EN
  logic [15:0] vtxCnt;
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) vtxCnt <= '0;
    else if (frameStart) vtxCnt <= '0;
    else if (vtxAcc && vtxCnt != 16'hFFFF) vtxCnt <= vtxCnt + 16'd1;
  end
  assign bus.oVtxCount = vtxCnt;
`else
  assign bus.oVtxCount = '0;
`endif

  assign bus.oBusy      = busyR;
  assign bus.oOverflow  = ovfR;
  assign bus.oVtxValid  = !empty;
  assign bus.oFrameDone = frameDone;
  assign bus.oObjCount  = objCnt;
  assign {bus.oVertexX, bus.oVertexY, bus.oVertexZ} = empty ? '0 : mem[rdPtr[AW-1:0]];
  assign {bus.oCamVerX, bus.oCamVerY, bus.oCamVerZ, bus.oCamDc} = camAct;
  assign {bus.oCosRoll, bus.oCosPitch, bus.oCosYaw, bus.oSenRoll, bus.oSenPitch,
          bus.oSenYaw, bus.oScaleX, bus.oScaleY, bus.oScaleZ, bus.oTranslX,
          bus.oTranslY, bus.oTranslZ} = objAct;
endmodule

// File: tb/tb_gp_input_stage.sv
// Directed vector bench for gp_input_stage: per-cycle table plus reset sequences.
module tb_gp_input_stage;
  logic iClock = 1'b0;
  logic iReset = 1'b0;
  int   passCnt = 0;
  int   totalCnt = 0;

`ifdef GP_INPUT_VTXCNT_EN
  localparam logic [15:0] EXP_VC = 16'd11;
`else
  localparam logic [15:0] EXP_VC = 16'd0;
`endif

  gp_input_stage_if #(.DATA_W(16)) bus ();
  gp_input_stage #(.FIFO_DEPTH(8), .DATA_W(16)) dut (.iClock(iClock), .iReset(iReset), .bus(bus));

  always #5 iClock = ~iClock;

  typedef struct {
    logic        en, obj, vtx, rdy;
    logic [15:0] sx, vx;
    logic        busy, ovf, vld;
    logic [15:0] hx, esx;
    logic [7:0]  cnt;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, obj, vtx, rdy, input logic [15:0] sx, vx,
                              input logic busy, ovf, vld, input logic [15:0] hx, esx,
                              input logic [7:0] cnt, input logic done);
    vec_t v;
    v.en = en; v.obj = obj; v.vtx = vtx; v.rdy = rdy; v.sx = sx; v.vx = vx;
    v.busy = busy; v.ovf = ovf; v.vld = vld; v.hx = hx; v.esx = esx; v.cnt = cnt; v.done = done;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    totalCnt++;
    if (act !== exp) $display("FAIL %s (step %0d): got %h expected %h", nm, idx, act, exp);
    else passCnt++;
  endtask

  task automatic applyVec(input vec_t v, input int idx);
    logic [15:0] ey;
    bus.iEnable = v.en; bus.iInitObj = v.obj; bus.iInitVtx = v.vtx; bus.iVtxReady = v.rdy;
    bus.iScaleX = v.sx; bus.iVertexX = v.vx;
    bus.iVertexY = v.vx ^ 16'h00F0; bus.iVertexZ = ~v.vx;
    @(posedge iClock);
    #1;
    ey = v.vld ? (v.hx ^ 16'h00F0) : 16'h0000;
    chk("busy",      idx, 32'(bus.oBusy),      32'(v.busy));
    chk("overflow",  idx, 32'(bus.oOverflow),  32'(v.ovf));
    chk("vtxValid",  idx, 32'(bus.oVtxValid),  32'(v.vld));
    chk("vertexX",   idx, 32'(bus.oVertexX),   32'(v.hx));
    chk("vertexY",   idx, 32'(bus.oVertexY),   32'(ey));
    chk("scaleX",    idx, 32'(bus.oScaleX),    32'(v.esx));
    chk("objCount",  idx, 32'(bus.oObjCount),  32'(v.cnt));
    chk("frameDone", idx, 32'(bus.oFrameDone), 32'(v.done));
    chk("camVerX",   idx, 32'(bus.oCamVerX),   32'h0123);
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, ".busy"},     0, 32'(bus.oBusy),     32'h0);
    chk({tag, ".overflow"}, 0, 32'(bus.oOverflow), 32'h0);
    chk({tag, ".vtxValid"}, 0, 32'(bus.oVtxValid), 32'h0);
    chk({tag, ".vertexX"},  0, 32'(bus.oVertexX),  32'h0);
    chk({tag, ".scaleX"},   0, 32'(bus.oScaleX),   32'h0);
    chk({tag, ".camVerX"},  0, 32'(bus.oCamVerX),  32'h0);
    chk({tag, ".objCount"}, 0, 32'(bus.oObjCount), 32'h0);
    chk({tag, ".vtxCount"}, 0, 32'(bus.oVtxCount), 32'h0);
    chk({tag, ".done"},     0, 32'(bus.oFrameDone), 32'h0);
  endtask

  initial begin
    int nB;
    bus.iEnable = 0; bus.iInitObj = 0; bus.iInitVtx = 0; bus.iVtxReady = 0;
    bus.iCamVerX = 16'h0123; bus.iCamVerY = 16'h0234; bus.iCamVerZ = 16'h0345; bus.iCamDc = 16'h0456;
    bus.iCosRoll = 16'h1111; bus.iCosPitch = 16'h2222; bus.iCosYaw = 16'h3333;
    bus.iSenRoll = 16'h4444; bus.iSenPitch = 16'h5555; bus.iSenYaw = 16'h6666;
    bus.iScaleX = 16'h0; bus.iScaleY = 16'h0100; bus.iScaleZ = 16'h0100;
    bus.iTranslX = 16'h0010; bus.iTranslY = 16'h0020; bus.iTranslZ = 16'h0030;
    bus.iVertexX = 16'h0; bus.iVertexY = 16'h0; bus.iVertexZ = 16'h0;

    // Frame A: vertex before any object, then an empty drain.
    vecs.push_back(mk(1,0,0,0, 16'h0, 16'h0,    0,0,0, 16'h0, 16'h0, 8'd0, 0));
    vecs.push_back(mk(1,0,1,0, 16'h0, 16'h0AAA, 0,1,0, 16'h0, 16'h0, 8'd0, 0));
    vecs.push_back(mk(0,0,0,0, 16'h0, 16'h0,    1,1,0, 16'h0, 16'h0, 8'd0, 0));
    vecs.push_back(mk(0,0,0,0, 16'h0, 16'h0,    1,1,0, 16'h0, 16'h0, 8'd0, 1));
    vecs.push_back(mk(0,0,0,0, 16'h0, 16'h0,    1,1,0, 16'h0, 16'h0, 8'd0, 0));
    // Frame B: fill, overflow, queued object change, end-of-frame drain.
    vecs.push_back(mk(1,0,0,0, 16'h0,    16'h0, 0,0,0, 16'h0, 16'h0,    8'd0, 0));
    vecs.push_back(mk(1,1,0,0, 16'h0200, 16'h0, 0,0,0, 16'h0, 16'h0200, 8'd1, 0));
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1,0,1,0, 16'h0, 16'(16'h0100 + i), (i == 8), 0, 1, 16'h0101, 16'h0200, 8'd1, 0));
    vecs.push_back(mk(1,0,1,0, 16'h0, 16'h0109, 1,1,1, 16'h0101, 16'h0200, 8'd1, 0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1,0,0,1, 16'h0, 16'h0, 0,1,1, 16'(16'h0102 + k), 16'h0200, 8'd1, 0));
    vecs.push_back(mk(1,1,0,0, 16'h0400, 16'h0, 1,1,1, 16'h0106, 16'h0200, 8'd2, 0));
    vecs.push_back(mk(1,0,0,1, 16'h0, 16'h0,    1,1,1, 16'h0107, 16'h0200, 8'd2, 0));
    vecs.push_back(mk(1,0,0,1, 16'h0, 16'h0,    1,1,1, 16'h0108, 16'h0200, 8'd2, 0));
    vecs.push_back(mk(1,0,0,1, 16'h0, 16'h0,    0,1,0, 16'h0,    16'h0400, 8'd2, 0));
    for (int j = 1; j <= 3; j++)
      vecs.push_back(mk(1,0,1,0, 16'h0, 16'(16'h0200 + j), 0,1,1, 16'h0201, 16'h0400, 8'd2, 0));
    vecs.push_back(mk(1,0,0,1, 16'h0, 16'h0, 0,1,1, 16'h0202, 16'h0400, 8'd2, 0));
    vecs.push_back(mk(0,0,0,0, 16'h0, 16'h0, 1,1,1, 16'h0202, 16'h0400, 8'd2, 0));
    vecs.push_back(mk(0,0,0,1, 16'h0, 16'h0, 1,1,1, 16'h0203, 16'h0400, 8'd2, 0));
    vecs.push_back(mk(0,0,0,1, 16'h0, 16'h0, 1,1,0, 16'h0,    16'h0400, 8'd2, 0));
    vecs.push_back(mk(0,0,0,0, 16'h0, 16'h0, 1,1,0, 16'h0,    16'h0400, 8'd2, 1));
    vecs.push_back(mk(0,0,0,0, 16'h0, 16'h0, 1,1,0, 16'h0,    16'h0400, 8'd2, 0));
    nB = vecs.size();
    // Frame C: same-cycle object+vertex on empty and non-empty FIFO, then 5 queued.
    vecs.push_back(mk(1,0,0,0, 16'h0,    16'h0,    0,0,0, 16'h0,    16'h0400, 8'd0, 0));
    vecs.push_back(mk(1,1,1,0, 16'h0300, 16'h0301, 0,0,1, 16'h0301, 16'h0300, 8'd1, 0));
    vecs.push_back(mk(1,1,1,0, 16'h0500, 16'h0302, 1,1,1, 16'h0301, 16'h0300, 8'd2, 0));
    vecs.push_back(mk(1,0,0,1, 16'h0,    16'h0,    0,1,0, 16'h0,    16'h0500, 8'd2, 0));
    for (int j = 1; j <= 5; j++)
      vecs.push_back(mk(1,0,1,0, 16'h0, 16'(16'h0302 + j), 0,1,1, 16'h0303, 16'h0500, 8'd2, 0));

    #1 iReset = 1'b1;
    #2 chkAllZero("reset");
    @(posedge iClock); @(posedge iClock);
    #3 iReset = 1'b0;
    @(posedge iClock); #1;
    chk("idle.busy",    0, 32'(bus.oBusy),    32'h1);
    chk("idle.camVerX", 0, 32'(bus.oCamVerX), 32'h0);

    for (int n = 0; n < nB; n++) applyVec(vecs[n], n);
    chk("vtxCount", nB, 32'(bus.oVtxCount), 32'(EXP_VC));
    for (int n = nB; n < vecs.size(); n++) applyVec(vecs[n], n);

    #2 iReset = 1'b1;
    #1 chkAllZero("midReset");
    bus.iEnable = 0; bus.iInitObj = 0; bus.iInitVtx = 0; bus.iVtxReady = 0;
    #2 iReset = 1'b0;
    @(posedge iClock); #1;
    chk("postReset.busy",  0, 32'(bus.oBusy),     32'h1);
    chk("postReset.valid", 0, 32'(bus.oVtxValid), 32'h0);
    bus.iEnable = 1;
    @(posedge iClock); #1;
    chk("postReset.start.busy", 0, 32'(bus.oBusy),    32'h0);
    chk("postReset.start.cam",  0, 32'(bus.oCamVerX), 32'h0123);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
